rv32i_fetch_controller: RTL and testbench
=========================================

Name: rv32i_fetch_controller

Overview:
Instruction fetch unit for the multicycle RV32I core; it is the producer end of the decoder's fetch-instruction input. It owns the PC, issues one instruction-memory read at a time over a valid/ready request channel, and takes the response. It then presents instruction + PC to decode under a valid/ready handshake and accepts PC redirects from the branch/EX stage.

Parameters:
INSTRUCTION_WIDTH, 32, width of a fetched instruction
WORD_SIZE, 32, PC/address width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
i_clk  in  1  core clock, rising edge
i_rst  in  1  asynchronous reset, active-low
o_imem_req_valid  out  1  read request valid
o_imem_req_addr  out  WORD_SIZE  read address (= PC)
i_imem_req_ready  in  1  memory accepts request
i_imem_resp_valid  in  1  read data valid (single-cycle pulse)
i_imem_resp_data  in  INSTRUCTION_WIDTH  read data
i_imem_resp_err  in  1  access fault, qualified by resp_valid
o_fetch_valid  out  1  instruction presented to decode
i_decode_ready  in  1  decode consumes instruction
o_fetch_instruction  out  INSTRUCTION_WIDTH  instruction to decode
o_fetch_pc  out  WORD_SIZE  PC of presented instruction
o_fetch_fault  out  1  presented instruction had access fault
o_fetch_misaligned  out  1  presented PC misaligned (see Optional Feature)
i_redirect_valid  in  1  PC redirect request (taken branch / jump)
i_redirect_pc  in  WORD_SIZE  redirect target

Behaviour:
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN. At most one outstanding memory request.
- Reset (i_rst low, async): state=S_IDLE, pc=RESET_PC. All outputs are 0, except o_imem_req_addr=RESET_PC and o_fetch_pc=RESET_PC.
- S_IDLE: always -> S_REQ on the next cycle.
- S_REQ: o_imem_req_valid=1, addr=pc.
  - Redirect with req_ready=0: pc<=target, stay in S_REQ. The address may change while valid is high, only in this case.
  - Redirect with req_ready=1: the old address is already accepted; pc<=target, -> S_DRAIN.
  - req_ready=1 with no redirect: -> S_WAIT.
- S_WAIT: request outstanding, o_imem_req_valid=0.
  - Redirect: pc<=target. If resp_valid in the same cycle, the response is discarded and -> S_REQ; otherwise -> S_DRAIN.
  - resp_valid with no redirect: latch data, err and pc into the output registers, -> S_HOLD.
- S_HOLD: o_fetch_valid=1. Outputs stay stable until the handshake completes.
  - Redirect: pc<=target, -> S_REQ, o_fetch_valid drops next cycle. A same-cycle decode_ready still counts as a completed transfer.
  - decode_ready with no redirect: pc<=pc+4, -> S_REQ.
- S_DRAIN: wait for resp_valid, discard it, -> S_REQ. A further redirect in S_DRAIN updates pc and stays in S_DRAIN.
- Priority: redirect over every other event, in every state except S_IDLE (redirect in S_IDLE is ignored).
- pc+4 wraps modulo 2^WORD_SIZE (32'hFFFF_FFFC -> 0).
- Fault: when resp_err=1, o_fetch_fault=1 and o_fetch_instruction=32'h0000_0013 (NOP); presented normally.
- Throughput with a zero-wait memory (ready=1, resp one cycle after accept) and decode_ready=1: 3 cycles per instruction, S_REQ -> S_WAIT -> S_HOLD.
- Unexpected resp_valid in S_IDLE, S_REQ or S_HOLD: ignored.

Optional Feature:
Macro: RV32I_FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect target with [1:0]!=0 is stored unmodified. On entering S_REQ with a misaligned pc, no memory request is issued; go directly to S_HOLD with o_fetch_misaligned=1, o_fetch_pc=pc, instruction=NOP, o_fetch_fault=0. From there, normal S_HOLD rules apply.
- Undefined: target[1:0] is forced to 2'b00 on load; o_fetch_misaligned is tied to 0.

Decomposition:
- Shared core package (rv32I_pkg): fetch state enum typedef, NOP_INSTR constant (32'h0000_0013), PC_INCREMENT (4).
- No sub-module. The PC register, incrementer and FSM are small and tightly coupled, so they live inline.

Test Plan:
1. Reset release, RESET_PC=0, zero-wait memory returning 0x00500093, decode_ready=1 -> addr 0 issued 1 cycle after S_IDLE; fetch_valid with instr 0x00500093, pc 0; next request addr 4; steady-state 3 cycles/instruction.
2. decode_ready=0 for 5 cycles in S_HOLD -> instruction/pc held stable, no new request; ready=1 -> next addr pc+4.
3. Redirect to 0x100 while in S_WAIT, response arrives 2 cycles later -> response dropped, never presented; next request addr 0x100.
4. Redirect 0x200 in the same cycle as req_ready=1 at addr 8 -> S_DRAIN, addr-8 response discarded, next request 0x200. Redirect 0x300 in the same cycle as S_HOLD handshake -> next request 0x300.
5. resp_err=1 with data 0xDEADBEEF -> fetch_valid, fault=1, instruction 0x00000013.
6. Wrap and feature checks:
   - pc 0xFFFFFFFC consumed -> next addr 0.
   - With RV32I_FETCH_MISALIGN_TRAP_EN, redirect 0x102 -> no imem request; fetch_valid, misaligned=1, pc 0x102.
   - Without the macro, redirect 0x102 -> request at 0x100.

Source files
------------

// File: rtl/rv32I_pkg.sv
// Shared core definitions for the RV32I fetch path.
//   fetch_state_e : fetch FSM states
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) presented on faults/traps
//   PC_INCREMENT  : sequential PC step in bytes
package rv32I_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam int unsigned PC_INCREMENT = 4;

endpackage

// File: rtl/rv32i_fetch_controller.sv
// Instruction fetch unit for the multicycle RV32I core.
// Owns the PC, issues one instruction-memory read at a time, and presents the
// returned instruction plus its PC to decode under a valid/ready handshake.
// Redirects from the branch/EX stage take priority over every other event.
//
// Ports:
//   i_clk, i_rst           : clock, asynchronous active-low reset
//   o_imem_req_*           : read request channel (valid/ready, address = PC)
//   i_imem_resp_*          : single-cycle read response (data, access fault)
//   o_fetch_*              : instruction/PC/fault/misaligned to decode, valid
//   i_decode_ready         : decode consumes the presented instruction
//   i_redirect_valid/_pc   : PC redirect (taken branch / jump)
//
// Build option RV32I_FETCH_MISALIGN_TRAP_EN: keep misaligned redirect targets
// and present them to decode as a misaligned NOP instead of fetching. Without
// it, redirect targets are word-aligned on load and o_fetch_misaligned is 0.
module rv32i_fetch_controller
    import rv32I_pkg::*;
#(
    parameter int unsigned          INSTRUCTION_WIDTH = 32,
    parameter int unsigned          WORD_SIZE         = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC          = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    output logic                         o_imem_req_valid,
    output logic [WORD_SIZE-1:0]         o_imem_req_addr,
    input  logic                         i_imem_req_ready,
    input  logic                         i_imem_resp_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] i_imem_resp_data,
    input  logic                         i_imem_resp_err,
    output logic                         o_fetch_valid,
    input  logic                         i_decode_ready,
    output logic [INSTRUCTION_WIDTH-1:0] o_fetch_instruction,
    output logic [WORD_SIZE-1:0]         o_fetch_pc,
    output logic                         o_fetch_fault,
    output logic                         o_fetch_misaligned,
    input  logic                         i_redirect_valid,
    input  logic [WORD_SIZE-1:0]         i_redirect_pc
);

    localparam logic [INSTRUCTION_WIDTH-1:0] Nop = INSTRUCTION_WIDTH'(NOP_INSTR);

    fetch_state_e                 state_q, state_d;
    logic [WORD_SIZE-1:0]         pc_q, pc_d;
    logic                         req_valid_q, req_valid_d;
    logic                         fetch_valid_q, fetch_valid_d;
    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
    logic [WORD_SIZE-1:0]         fetch_pc_q, fetch_pc_d;
    logic                         fault_q, fault_d;
    logic                         mis_q, mis_d;
    logic [WORD_SIZE-1:0]         target;

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    assign target = i_redirect_pc;
`else
    assign target = i_redirect_pc & ~WORD_SIZE'(3);
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        fetch_pc_d = fetch_pc_q;
        fault_d    = fault_q;
        mis_d      = mis_q;

        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (i_redirect_valid) begin
                    // With ready high the old address is already accepted and
                    // its response must be drained before re-requesting.
                    pc_d    = target;
                    state_d = i_imem_req_ready ? S_DRAIN : S_REQ;
                end else if (i_imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_redirect_valid) begin
                    pc_d    = target;
                    state_d = i_imem_resp_valid ? S_REQ : S_DRAIN;
                end else if (i_imem_resp_valid) begin
                    instr_d    = i_imem_resp_err ? Nop : i_imem_resp_data;
                    fault_d    = i_imem_resp_err;
                    fetch_pc_d = pc_q;
                    mis_d      = 1'b0;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_redirect_valid) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (i_decode_ready) begin
                    pc_d    = pc_q + WORD_SIZE'(PC_INCREMENT);
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (i_redirect_valid) begin
                    pc_d = target;
                end
                // The outstanding request completes here even if a redirect
                // arrives alongside it, otherwise the FSM would never leave.
                if (i_imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
        // A misaligned PC never reaches memory: present it straight to decode.
        if (state_d == S_REQ && pc_d[1:0] != 2'b00) begin
            state_d    = S_HOLD;
            instr_d    = Nop;
            fault_d    = 1'b0;
            fetch_pc_d = pc_d;
            mis_d      = 1'b1;
        end
`else
        mis_d = 1'b0;
`endif

        req_valid_d   = (state_d == S_REQ);
        fetch_valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            req_valid_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            instr_q       <= '0;
            fetch_pc_q    <= RESET_PC;
            fault_q       <= 1'b0;
            mis_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_valid_q   <= req_valid_d;
            fetch_valid_q <= fetch_valid_d;
            instr_q       <= instr_d;
            fetch_pc_q    <= fetch_pc_d;
            fault_q       <= fault_d;
            mis_q         <= mis_d;
        end
    end

    assign o_imem_req_valid    = req_valid_q;
    assign o_imem_req_addr     = pc_q;
    assign o_fetch_valid       = fetch_valid_q;
    assign o_fetch_instruction = instr_q;
    assign o_fetch_pc          = fetch_pc_q;
    assign o_fetch_fault       = fault_q;
    assign o_fetch_misaligned  = mis_q;

endmodule

// File: tb/tb_rv32i_fetch_controller.sv
// Self-checking bench for rv32i_fetch_controller: directed scenarios followed
// by randomized memory/decode/redirect traffic, all checked every cycle against
// a transaction-level model (outstanding request, drop flag, presented slot).
module tb_rv32i_fetch_controller;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, resp_valid, resp_err;
    logic [31:0] req_addr, resp_data;
    logic        fetch_valid, decode_ready, fetch_fault, fetch_mis;
    logic [31:0] fetch_instr, fetch_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    rv32i_fetch_controller dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .o_imem_req_valid    (req_valid),
        .o_imem_req_addr     (req_addr),
        .i_imem_req_ready    (req_ready),
        .i_imem_resp_valid   (resp_valid),
        .i_imem_resp_data    (resp_data),
        .i_imem_resp_err     (resp_err),
        .o_fetch_valid       (fetch_valid),
        .i_decode_ready      (decode_ready),
        .o_fetch_instruction (fetch_instr),
        .o_fetch_pc          (fetch_pc),
        .o_fetch_fault       (fetch_fault),
        .o_fetch_misaligned  (fetch_mis),
        .i_redirect_valid    (redirect),
        .i_redirect_pc       (redirect_pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model
    bit          m_started, m_busy, m_drop, m_have, m_fault, m_mis;
    logic [31:0] m_pc, m_instr, m_fpc;

    // Memory model and knobs
    bit          mem_busy, resp_real;
    int          mem_cnt;
    int          k_ready, k_lat, k_err, k_spur;
    bit          k_fixed;
    logic [31:0] k_data;

    // Latest samples and phase-1 record
    bit          s_rv, s_fv, s_fault, s_mis;
    logic [31:0] s_addr, s_pc, s_instr;
    int          cyc;
    bit          rec_done;
    bit          r_rv [16];
    bit          r_fv [16];
    logic [31:0] r_addr [16];
    logic [31:0] r_pc [16];
    logic [31:0] r_instr [16];
    int          nrv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_rv();
        return m_started && !m_busy && !m_have;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] t);
        return MIS_EN ? t : (t & 32'hFFFF_FFFC);
    endfunction

    task automatic model_update();
        bit acc;
        bit cons;
        if (!m_started) begin
            m_started = 1'b1;
        end else begin
            acc  = exp_rv() && req_ready;
            cons = m_have && decode_ready;
            if (acc) begin
                m_busy = 1'b1;
                m_drop = redirect;
                if (redirect) m_pc = align(redirect_pc);
            end else if (m_busy) begin
                if (redirect) m_drop = 1'b1;
                if (resp_valid) begin
                    m_busy = 1'b0;
                    if (!m_drop) begin
                        m_have  = 1'b1;
                        m_instr = resp_err ? NOP : resp_data;
                        m_fault = resp_err;
                        m_fpc   = m_pc;
                        m_mis   = 1'b0;
                    end
                    m_drop = 1'b0;
                end
                if (redirect) m_pc = align(redirect_pc);
            end else if (m_have && (redirect || cons)) begin
                m_have = 1'b0;
                m_pc   = redirect ? align(redirect_pc) : m_pc + 32'd4;
            end else if (redirect) begin
                m_pc = align(redirect_pc);
            end
            if (MIS_EN && !m_busy && !m_have && m_pc[1:0] != 2'b00) begin
                m_have  = 1'b1;
                m_instr = NOP;
                m_fault = 1'b0;
                m_fpc   = m_pc;
                m_mis   = 1'b1;
            end
        end
    endtask

    task automatic drive_mem();
        req_ready = ($urandom_range(99) < k_ready);
        resp_real = mem_busy && (mem_cnt == 0);
        if (resp_real) begin
            resp_valid = 1'b1;
            resp_data  = k_fixed ? k_data : $urandom;
            resp_err   = ($urandom_range(99) < k_err);
        end else begin
            resp_valid = !mem_busy && ($urandom_range(99) < k_spur);
            resp_data  = $urandom;
            resp_err   = $urandom_range(1) == 1;
        end
    endtask

    task automatic compare();
        chk("req_valid", 32'(req_valid), 32'(exp_rv()));
        chk("req_addr", req_addr, m_pc);
        chk("fetch_valid", 32'(fetch_valid), 32'(m_have));
        if (m_have) begin
            chk("fetch_instr", fetch_instr, m_instr);
            chk("fetch_pc", fetch_pc, m_fpc);
            chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
            chk("fetch_mis", 32'(fetch_mis), 32'(m_mis));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        if (resp_real) mem_busy = 1'b0;
        else if (mem_busy && mem_cnt > 0) mem_cnt--;
        if (s_rv && req_ready) begin
            mem_busy = 1'b1;
            mem_cnt  = $urandom_range(k_lat);
        end
        @(negedge clk);
        s_rv = req_valid;  s_addr = req_addr;  s_fv = fetch_valid;
        s_pc = fetch_pc;   s_instr = fetch_instr;
        s_fault = fetch_fault;  s_mis = fetch_mis;
        compare();
        if (!rec_done && cyc < 16) begin
            r_rv[cyc] = s_rv;  r_fv[cyc] = s_fv;  r_addr[cyc] = s_addr;
            r_pc[cyc] = s_pc;  r_instr[cyc] = s_instr;
        end
        cyc++;
        drive_mem();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_req_addr", req_addr, 32'd0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_fetch_pc", fetch_pc, 32'd0);
        chk("rst_fetch_instr", fetch_instr, 32'd0);
        chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        chk("rst_fetch_mis", 32'(fetch_mis), 32'd0);
        m_started = 0; m_busy = 0; m_drop = 0; m_have = 0;
        m_pc = 32'd0; m_fpc = 32'd0; m_instr = 32'd0; m_fault = 0; m_mis = 0;
        mem_busy = 0; mem_cnt = 0; resp_real = 0; s_rv = 0; s_fv = 0;
        redirect = 0; redirect_pc = 0; decode_ready = 0;
        req_ready = 0; resp_valid = 0; resp_data = 0; resp_err = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        drive_mem();
    endtask

    task automatic wait_rv();
        int n = 0;
        while (!s_rv && n < 64) begin
            step();
            n++;
        end
        chk("wait_req_timeout", 32'(s_rv), 32'd1);
    endtask

    task automatic wait_fv();
        int n = 0;
        nrv = 0;
        while (!s_fv && n < 64) begin
            nrv += int'(s_rv);
            step();
            n++;
        end
        chk("wait_fetch_timeout", 32'(s_fv), 32'd1);
    endtask

    initial begin
        int r;
        k_ready = 100; k_lat = 0; k_err = 0; k_spur = 0;
        k_fixed = 1'b1; k_data = 32'h0050_0093;
        rec_done = 1'b0;
        do_reset();

        // Zero-wait memory, decode always ready: 3 cycles per instruction
        decode_ready = 1'b1;
        repeat (8) step();
        rec_done = 1'b1;
        chk("p1_c0_rv", 32'(r_rv[0]), 32'd1);
        chk("p1_c0_addr", r_addr[0], 32'd0);
        chk("p1_c1_rv", 32'(r_rv[1]), 32'd0);
        chk("p1_c2_fv", 32'(r_fv[2]), 32'd1);
        chk("p1_c2_instr", r_instr[2], 32'h0050_0093);
        chk("p1_c2_pc", r_pc[2], 32'd0);
        chk("p1_c3_rv", 32'(r_rv[3]), 32'd1);
        chk("p1_c3_addr", r_addr[3], 32'd4);
        chk("p1_c5_fv", 32'(r_fv[5]), 32'd1);
        chk("p1_c5_pc", r_pc[5], 32'd4);
        chk("p1_c6_addr", r_addr[6], 32'd8);

        // Decode stalls for 5 cycles: no new request while holding
        decode_ready = 1'b0;
        wait_fv();
        nrv = 0;
        repeat (5) begin
            step();
            nrv += int'(s_rv);
        end
        chk("hold_no_req", 32'(nrv), 32'd0);
        chk("hold_valid", 32'(s_fv), 32'd1);
        decode_ready = 1'b1;
        step();
        chk("after_hold_req", 32'(s_rv), 32'd1);

        // Redirect while waiting on a slow response
        k_lat = 2;
        wait_rv();
        step();
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        wait_fv();
        chk("redir_wait_pc", s_pc, 32'h100);

        // Redirect on the accept cycle, then on the decode handshake
        k_lat = 0;
        wait_rv();
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        wait_fv();
        chk("redir_accept_pc", s_pc, 32'h200);
        redirect = 1'b1; redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        wait_fv();
        chk("redir_hold_pc", s_pc, 32'h300);

        // Access fault presents a NOP
        k_err = 100; k_data = 32'hDEAD_BEEF;
        step();
        wait_fv();
        chk("fault_flag", 32'(s_fault), 32'd1);
        chk("fault_instr", s_instr, NOP);
        k_err = 0; k_data = 32'h0050_0093;

        // PC wrap
        decode_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        wait_fv();
        chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
        decode_ready = 1'b1;
        step();
        chk("wrap_rv", 32'(s_rv), 32'd1);
        chk("wrap_addr", s_addr, 32'd0);

        // Misaligned redirect
        wait_fv();
        decode_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        wait_fv();
        chk("mis_req_count", 32'(nrv), MIS_EN ? 32'd0 : 32'd1);
        chk("mis_flag", 32'(s_mis), 32'(MIS_EN));
        chk("mis_pc", s_pc, MIS_EN ? 32'h102 : 32'h100);
        chk("mis_instr", s_instr, MIS_EN ? NOP : 32'h0050_0093);

        // Randomized traffic, with an asynchronous reset in the middle
        k_ready = 70; k_lat = 3; k_err = 20; k_spur = 10; k_fixed = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            decode_ready = ($urandom_range(99) < 60);
            redirect     = ($urandom_range(99) < 8);
            r = int'($urandom_range(9));
            if (r == 0)      redirect_pc = 32'hFFFF_FFFC;
            else if (r == 1) redirect_pc = $urandom;
            else             redirect_pc = $urandom & 32'hFFFF_FFFC;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
